hamming_secded_rd_decoder: RTL and testbench
============================================

Name: hamming_secded_rd_decoder

Overview:
- Read-side SECDED Hamming decoder for one port of the banked dual-port memory.
- Accepts the stored codeword from the memory read path, checks and corrects it, and presents data after a fixed read latency.
- Flags single-bit errors (corrected) and double-bit errors (uncorrectable), and keeps saturating error counters for status readout.
- It is the reverse direction of the write-side encoder: it consumes exactly the codeword layout the encoder produces.

Parameters:
- DATA_WIDTH, 8: width of the user data word.
- RD_LATENCY, 5: cycles from codeword accept to rd_valid. Must be ≥1. Set to RD_LATENCYA or RD_LATENCYB per port.
- CNT_WIDTH, 8: width of the error counters.
- PARITY_BITS, derived: smallest P with 2^P ≥ DATA_WIDTH+P+1. Equals 4 for the default.
- CODE_WIDTH, derived: DATA_WIDTH+PARITY_BITS+1. Equals 13 for the default.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cw_valid  in  1  codeword present on cw_in this cycle.
- cw_in  in  CODE_WIDTH  raw codeword from memory.
- cnt_clr  in  1  synchronous clear of both counters.
- rd_valid  out  1  decoded result valid.
- rd_data  out  DATA_WIDTH  corrected data.
- sbe  out  1  single-bit error detected and corrected.
- dbe  out  1  uncorrectable error.
- syndrome  out  PARITY_BITS  Hamming syndrome of the word.
- sbe_cnt  out  CNT_WIDTH  saturating count of sbe events.
- dbe_cnt  out  CNT_WIDTH  saturating count of dbe events.

Behaviour:
- Codeword layout:
  - cw[0] is the overall parity; XOR of all CODE_WIDTH bits is 0 for a clean word.
  - cw[i] for i=1..CODE_WIDTH-1 is Hamming position i.
  - Power-of-two positions hold parity bits.
  - Remaining positions hold data in ascending order, with data[0] at position 3.
- Decode, per accepted word:
  - s = XOR of indices i (i≥1) where cw[i]=1.
  - p = XOR of all bits.
- Classification:
  - s=0, p=0: clean. sbe=0, dbe=0.
  - p=1, s=0: cw[0] is in error. sbe=1; data unchanged.
  - p=1, 1≤s≤CODE_WIDTH-1: flip cw[s] before data extraction. sbe=1.
  - p=1, s>CODE_WIDTH-1: invalid position. dbe=1, sbe=0; data extracted uncorrected.
  - s≠0, p=0: dbe=1; data extracted uncorrected.
- Latency and pipeline:
  - Fixed pipeline with no backpressure.
  - A word accepted at edge N (cw_valid=1) produces rd_valid=1 for exactly one cycle, with rd_data/sbe/dbe/syndrome, in the cycle after edge N+RD_LATENCY-1. For RD_LATENCY=1 this means registered outputs on the next cycle.
  - Back-to-back cw_valid gives back-to-back rd_valid in the same order. Throughput is one word per cycle.
  - Decode logic sits in stage 1; the remaining RD_LATENCY-1 stages are delay registers. Each stage carries a valid bit.
  - When rd_valid=0: rd_data, sbe, dbe and syndrome are 0. sbe and dbe are never both 1.
- Counters:
  - On each rd_valid with sbe=1, sbe_cnt increments; likewise dbe_cnt for dbe=1. Both saturate at 2^CNT_WIDTH-1.
  - cnt_clr has priority: a clear and an event in the same cycle leaves the count at 0.
- Reset (any time, including with words in flight):
  - All stage valids, rd_valid, rd_data, sbe, dbe, syndrome, sbe_cnt and dbe_cnt go to 0 immediately.
  - In-flight words are discarded and never emerge.
  - The first word accepted after rst_n deasserts follows normal latency.

Test Plan:
- Clean word: cw_in=13'h144E with cw_valid for one cycle → rd_valid exactly 5 cycles later. rd_data=8'hA5, sbe=0, dbe=0, syndrome=0. Counters stay 0.
- Data-region single error: cw_in=13'h140E (bit 6 flipped) → rd_data=8'hA5, sbe=1, dbe=0, syndrome=6, sbe_cnt=1.
- Overall-parity single error: cw_in=13'h144F → rd_data=8'hA5, sbe=1, dbe=0, syndrome=0.
- Double and triple errors:
  - cw_in=13'h1466 (bits 3 and 5 flipped) → dbe=1, sbe=0, syndrome=6, rd_data=8'hA6 (uncorrected), dbe_cnt=1.
  - cw_in=13'h0448 (bits 1, 2, 12 flipped) → syndrome=15, dbe=1.
- Streaming and saturation:
  - 300 consecutive cycles of 13'h140E → 300 consecutive rd_valid pulses, in order.
  - With CNT_WIDTH=8, sbe_cnt holds at 255.
  - cnt_clr asserted in the same cycle as an sbe event → sbe_cnt=0.
- Reset mid-flight: 3 words accepted, rst_n pulled low 2 cycles later → all outputs 0 immediately and no rd_valid from those words. A word sent after release appears 5 cycles later.

Source files
------------

// File: rtl/hamming_secded_rd_decoder_if.sv
// Bundle between the memory read path and the SECDED read decoder.
// cw_valid qualifies cw_in for one cycle and rd_valid qualifies the results for one cycle; there is no ready.
interface hamming_secded_rd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  function automatic int calc_parity_bits(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) begin
      p++;
    end
    return p;
  endfunction

  localparam int PARITY_BITS = calc_parity_bits(DATA_WIDTH);
  localparam int CODE_WIDTH  = DATA_WIDTH + PARITY_BITS + 1;

  logic                   cw_valid;
  logic [CODE_WIDTH-1:0]  cw_in;
  logic                   cnt_clr;
  logic                   rd_valid;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   sbe;
  logic                   dbe;
  logic [PARITY_BITS-1:0] syndrome;
  logic [CNT_WIDTH-1:0]   sbe_cnt;
  logic [CNT_WIDTH-1:0]   dbe_cnt;

  modport master (
    output cw_valid, cw_in, cnt_clr,
    input  rd_valid, rd_data, sbe, dbe, syndrome, sbe_cnt, dbe_cnt
  );

  modport slave (
    input  cw_valid, cw_in, cnt_clr,
    output rd_valid, rd_data, sbe, dbe, syndrome, sbe_cnt, dbe_cnt
  );
endinterface

// File: rtl/hamming_secded_rd_decoder.sv
// SECDED Hamming read-side decoder: decode in stage 1, then RD_LATENCY-1 delay stages,
// plus saturating single/double error counters fed from the output stage.
module hamming_secded_rd_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 5,
  parameter int CNT_WIDTH  = 8
) (
  input logic                         clk,
  input logic                         rst_n,
  hamming_secded_rd_decoder_if.slave  bus
);
  function automatic int calc_parity_bits(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) begin
      p++;
    end
    return p;
  endfunction

  // k-th non-power-of-two Hamming position, i.e. where data bit k lives.
  function automatic int data_pos(input int k);
    int cnt;
    cnt = 0;
    for (int i = 3; i < 1024; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == k) return i;
        cnt++;
      end
    end
    return 0;
  endfunction

  localparam int PB = calc_parity_bits(DATA_WIDTH);
  localparam int CW = DATA_WIDTH + PB + 1;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  sbe;
    logic                  dbe;
    logic [PB-1:0]         syn;
  } stage_t;

  logic [PB-1:0]         syn_c;
  logic                  par_c;
  logic                  in_range_c;
  logic [CW-1:0]         flip_c;
  logic [CW-1:0]         fixed_c;
  logic [DATA_WIDTH-1:0] data_c;
  stage_t                stage_in;
  stage_t                stage_q [RD_LATENCY];
  logic [CNT_WIDTH-1:0]  sbe_cnt_q;
  logic [CNT_WIDTH-1:0]  dbe_cnt_q;

  always_comb begin
    syn_c = '0;
    for (int i = 1; i < CW; i++) begin
      if (bus.cw_in[i]) syn_c = syn_c ^ PB'(i);
    end
    par_c      = ^bus.cw_in;
    in_range_c = (32'(syn_c) <= 32'(CW - 1));

    // Only an odd-weight error with an in-range nonzero syndrome is corrected in place.
    flip_c = '0;
    for (int i = 1; i < CW; i++) begin
      flip_c[i] = par_c && (syn_c == PB'(i));
    end
    fixed_c = bus.cw_in ^ flip_c;

    data_c = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      data_c[k] = fixed_c[data_pos(k)];
    end

    stage_in       = '0;
    stage_in.valid = bus.cw_valid;
    if (bus.cw_valid) begin
      stage_in.data = data_c;
      stage_in.syn  = syn_c;
      stage_in.sbe  = par_c && in_range_c;
      stage_in.dbe  = (par_c && !in_range_c) || (!par_c && (syn_c != '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= stage_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign bus.rd_valid = stage_q[RD_LATENCY-1].valid;
  assign bus.rd_data  = stage_q[RD_LATENCY-1].data;
  assign bus.sbe      = stage_q[RD_LATENCY-1].sbe;
  assign bus.dbe      = stage_q[RD_LATENCY-1].dbe;
  assign bus.syndrome = stage_q[RD_LATENCY-1].syn;

  // Clear wins over a same-cycle event; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      if (bus.rd_valid && bus.sbe && (sbe_cnt_q != '1)) sbe_cnt_q <= sbe_cnt_q + 1'b1;
      if (bus.rd_valid && bus.dbe && (dbe_cnt_q != '1)) dbe_cnt_q <= dbe_cnt_q + 1'b1;
    end
  end

  assign bus.sbe_cnt = sbe_cnt_q;
  assign bus.dbe_cnt = dbe_cnt_q;
endmodule

// File: tb/tb_hamming_secded_rd_decoder.sv
// Bench for hamming_secded_rd_decoder: directed vectors, randomized encode+inject traffic,
// streaming saturation, clear priority and mid-flight reset, checked through an expected queue.
module tb_hamming_secded_rd_decoder;
  localparam int DW   = 8;
  localparam int L    = 5;
  localparam int CNTW = 8;
  localparam int PBW  = 4;
  localparam int CWID = 13;
  localparam int EW   = 32 + DW + 1 + 1 + PBW;
  localparam int CMAX = (1 << CNTW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hamming_secded_rd_decoder_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CNTW)) bus ();

  hamming_secded_rd_decoder #(
    .DATA_WIDTH(DW),
    .RD_LATENCY(L),
    .CNT_WIDTH (CNTW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int m_sbe = 0;
  int m_dbe = 0;
  int dpos[DW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: encoder and raw data extraction by Hamming position
  function automatic logic [CWID-1:0] encode(input logic [DW-1:0] d);
    logic [CWID-1:0] cw;
    cw = '0;
    for (int k = 0; k < DW; k++) cw[dpos[k]] = d[k];
    for (int j = 0; j < PBW; j++) begin
      logic b;
      b = 1'b0;
      for (int i = 1; i < CWID; i++) begin
        if (((i >> j) & 1) == 1) b = b ^ cw[i];
      end
      cw[1 << j] = b;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [CWID-1:0] cw);
    logic [DW-1:0] d;
    for (int k = 0; k < DW; k++) d[k] = cw[dpos[k]];
    return d;
  endfunction

  // driver tasks
  task automatic send(input logic [CWID-1:0] cw, input logic [DW-1:0] d,
                      input logic s, input logic db, input logic [PBW-1:0] syn);
    @(posedge clk);
    #1;
    bus.cw_valid = 1'b1;
    bus.cw_in    = cw;
    exp_q.push_back({32'(cyc + L), d, s, db, syn});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.cw_valid = 1'b0;
      bus.cw_in    = '0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    idle(2);
  endtask

  // scoreboard / monitor
  logic [EW-1:0] mon_e;
  logic          ev_s, ev_d;
  always @(negedge clk) begin
    check("sbe_cnt", 32'(bus.sbe_cnt), 32'(m_sbe));
    check("dbe_cnt", 32'(bus.dbe_cnt), 32'(m_dbe));
    ev_s = 1'b0;
    ev_d = 1'b0;
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
      check("missing_rd_valid", 0, 1);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
      mon_e = exp_q.pop_front();
      check("rd_valid", 32'(bus.rd_valid), 1);
      check("rd_data", 32'(bus.rd_data), 32'(mon_e[PBW+2 +: DW]));
      check("sbe", 32'(bus.sbe), 32'(mon_e[PBW+1]));
      check("dbe", 32'(bus.dbe), 32'(mon_e[PBW]));
      check("syndrome", 32'(bus.syndrome), 32'(mon_e[PBW-1:0]));
      ev_s = mon_e[PBW+1];
      ev_d = mon_e[PBW];
    end else begin
      check("idle_outputs", 32'({bus.rd_valid, bus.rd_data, bus.sbe, bus.dbe, bus.syndrome}), 0);
    end
    if (!rst_n || bus.cnt_clr) begin
      m_sbe = 0;
      m_dbe = 0;
    end else begin
      if (ev_s && m_sbe < CMAX) m_sbe++;
      if (ev_d && m_dbe < CMAX) m_dbe++;
    end
  end

  initial begin
    int k;
    k = 0;
    for (int i = 1; i < CWID; i++) begin
      if ($countones(i) != 1) begin
        dpos[k] = i;
        k++;
      end
    end
    rst_n        = 1'b0;
    bus.cw_valid = 1'b0;
    bus.cw_in    = '0;
    bus.cnt_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({bus.rd_valid, bus.rd_data, bus.sbe, bus.dbe, bus.syndrome,
                               bus.sbe_cnt, bus.dbe_cnt}), 0);
    check("encoder_model", 32'(encode(8'hA5)), 32'h144E);
    rst_n = 1'b1;

    // directed vectors
    send(13'h144E, 8'hA5, 1'b0, 1'b0, 4'd0);  idle(L + 1);
    send(13'h140E, 8'hA5, 1'b1, 1'b0, 4'd6);  idle(1);
    send(13'h144F, 8'hA5, 1'b1, 1'b0, 4'd0);
    send(13'h1466, 8'hA6, 1'b0, 1'b1, 4'd6);
    send(13'h0448, 8'h25, 1'b0, 1'b1, 4'd15);
    idle(1);
    drain();
    check("sbe_cnt_directed", 32'(bus.sbe_cnt), 2);
    check("dbe_cnt_directed", 32'(bus.dbe_cnt), 2);

    // random: encode, inject 0/1/2 distinct bit flips, derive expectation from the injection
    for (int n = 0; n < 200; n++) begin
      logic [DW-1:0]   d;
      logic [CWID-1:0] cw;
      int nf, a, b;
      d  = DW'($urandom_range(0, 255));
      cw = encode(d);
      nf = $urandom_range(0, 2);
      a  = $urandom_range(0, CWID - 1);
      b  = (a + $urandom_range(1, CWID - 1)) % CWID;
      if (nf == 0) begin
        send(cw, d, 1'b0, 1'b0, '0);
      end else if (nf == 1) begin
        cw[a] = ~cw[a];
        send(cw, d, 1'b1, 1'b0, PBW'(a));
      end else begin
        cw[a] = ~cw[a];
        cw[b] = ~cw[b];
        send(cw, extract(cw), 1'b0, 1'b1, PBW'(a ^ b));
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    drain();

    // reset with words in flight
    send(13'h140E, 8'hA5, 1'b1, 1'b0, 4'd6);
    send(13'h1466, 8'hA6, 1'b0, 1'b1, 4'd6);
    send(13'h144E, 8'hA5, 1'b0, 1'b0, 4'd0);
    idle(1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_sbe = 0;
    m_dbe = 0;
    #1;
    check("reset_midflight", 32'({bus.rd_valid, bus.rd_data, bus.sbe, bus.dbe, bus.syndrome,
                                   bus.sbe_cnt, bus.dbe_cnt}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(13'h144F, 8'hA5, 1'b1, 1'b0, 4'd0);
    idle(1);
    drain();

    // streaming to saturation
    for (int n = 0; n < 300; n++) send(13'h140E, 8'hA5, 1'b1, 1'b0, 4'd6);
    idle(1);
    drain();
    check("sbe_cnt_saturated", 32'(bus.sbe_cnt), 32'(CMAX));

    // clear in the same cycle as an sbe result
    send(13'h140E, 8'hA5, 1'b1, 1'b0, 4'd6);
    idle(1);
    repeat (L - 1) @(posedge clk);
    #1;
    check("rd_valid_at_clear", 32'(bus.rd_valid & bus.sbe), 1);
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    check("clear_priority", 32'(bus.sbe_cnt), 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
